// File: rtl/gate_sweep_bist.sv
// -----------------------------------------------------------------------------
// gate_sweep_bist
//
// Exhaustive truth-table self-checker for an N_IN-input combinational gate.
// It walks the stim vector through 0 .. 2^N_IN-1, holds each vector for SETTLE
// cycles and then samples dut_y against a built-in reference. The reference
// function is chosen by op and latched at start. The checker counts mismatching
// vectors and records the first failing vector.
//
// Parameters
//   N_IN    number of gate inputs (1..8)
//   SETTLE  cycles each vector is held before dut_y is sampled (>= 1)
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous, active-low reset
//   start       begin a sweep (accepted only in IDLE or DONE, op <= 5)
//   abort       leave any active state and return to IDLE
//   op          reference: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR
//   dut_y       output of the gate under test
//   stim        vector currently applied to the gate under test
//   busy        sweep in progress
//   done        sweep complete, results valid
//   pass        with done: no mismatches were seen
//   err_count   number of mismatching vectors (0 .. 2^N_IN)
//   first_fail  stim value of the first mismatch
//   fail_seen   first_fail holds a valid vector
// -----------------------------------------------------------------------------
module gate_sweep_bist #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [2:0]      op,
    input  logic            dut_y,
    output logic [N_IN-1:0] stim,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_fail,
    output logic            fail_seen
);

    // A 1-bit counter is kept even when SETTLE is 1 so the vector is never zero width.
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
    localparam logic [N_IN-1:0]  STIM_ALL = {N_IN{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t           state;
    logic [2:0]       op_q;
    logic [CNT_W-1:0] settle_cnt;

    logic             exp_y;
    logic             mismatch;
    logic [N_IN:0]    err_inc;

    // Reference gate: codes 3..5 are the inverted forms of codes 0..2.
    function automatic logic ref_gate(input logic [2:0] f, input logic [N_IN-1:0] v);
        logic r;
        case (f)
            3'd0, 3'd3: r = &v;
            3'd1, 3'd4: r = |v;
            default:    r = ^v;
        endcase
        if (f >= 3'd3) begin
            r = ~r;
        end
        return r;
    endfunction

    // Saturating count: it can reach at most 2^N_IN, but it must never wrap.
    function automatic logic [N_IN:0] sat_inc(input logic [N_IN:0] c, input logic en);
        if (en && !(&c)) begin
            return c + (N_IN+1)'(1);
        end
        return c;
    endfunction

    always_comb begin
        exp_y    = ref_gate(op_q, stim);
        mismatch = (dut_y != exp_y);
        err_inc  = sat_inc(err_count, mismatch);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            op_q       <= 3'd0;
            settle_cnt <= '0;
            stim       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            first_fail <= '0;
            fail_seen  <= 1'b0;
        end else if (abort && (state != S_IDLE)) begin
            // Results are left in place so a halted sweep can still be inspected.
            state      <= S_IDLE;
            settle_cnt <= '0;
            stim       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    // abort also blocks start while already in IDLE.
                    if (start && !abort && (op <= 3'd5)) begin
                        state      <= S_WAIT;
                        op_q       <= op;
                        settle_cnt <= '0;
                        stim       <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        err_count  <= '0;
                        first_fail <= '0;
                        fail_seen  <= 1'b0;
                    end
                end

                S_WAIT: begin
                    if (settle_cnt == CNT_LAST) begin
                        settle_cnt <= '0;
                        state      <= S_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + CNT_W'(1);
                    end
                end

                S_CHECK: begin
                    err_count <= err_inc;
                    if (mismatch && !fail_seen) begin
                        first_fail <= stim;
                        fail_seen  <= 1'b1;
                    end
                    if (stim == STIM_ALL) begin
                        // pass includes the vector being checked on this cycle.
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_inc == '0);
                    end else begin
                        stim  <= stim + N_IN'(1);
                        state <= S_WAIT;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_sweep_bist.sv
module tb_gate_sweep_bist;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A: N_IN=2, SETTLE=1
    logic       start_a, abort_a, dut_y_a, busy_a, done_a, pass_a, fs_a;
    logic [2:0] op_a;
    logic [1:0] stim_a, ff_a;
    logic [2:0] err_a;
    int         mode_a;
    logic [2:0] mfn_a;

    // Instance B: N_IN=3, SETTLE=3
    logic       start_b, abort_b, dut_y_b, busy_b, done_b, pass_b, fs_b;
    logic [2:0] op_b;
    logic [2:0] stim_b, ff_b;
    logic [3:0] err_b;
    int         mode_b;
    logic [2:0] mfn_b;

    // Instance C: N_IN=2, SETTLE=2
    logic       start_c, abort_c, dut_y_c, busy_c, done_c, pass_c, fs_c;
    logic [2:0] op_c;
    logic [1:0] stim_c, ff_c;
    logic [2:0] err_c;
    int         mode_c;
    logic [2:0] mfn_c;

    int checks = 0;
    int errors = 0;

    // Gate-under-test model: mode 0 = gate of function fn, 1 = stuck-at-0, 2 = stuck-at-1.
    function automatic logic gate_model(input int mode, input logic [2:0] fn,
                                        input logic [7:0] v, input int n);
        int ones;
        logic all1, any1, par;
        if (mode == 1) return 1'b0;
        if (mode == 2) return 1'b1;
        ones = 0;
        for (int i = 0; i < n; i++) if (v[i]) ones++;
        all1 = (ones == n);
        any1 = (ones != 0);
        par  = ones[0];
        case (fn)
            3'd0: return all1;
            3'd1: return any1;
            3'd2: return par;
            3'd3: return !all1;
            3'd4: return !any1;
            default: return !par;
        endcase
    endfunction

    assign dut_y_a = gate_model(mode_a, mfn_a, 8'(stim_a), 2);
    assign dut_y_b = gate_model(mode_b, mfn_b, 8'(stim_b), 3);
    assign dut_y_c = gate_model(mode_c, mfn_c, 8'(stim_c), 2);

    gate_sweep_bist #(.N_IN(2), .SETTLE(1)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .op(op_a),
        .dut_y(dut_y_a), .stim(stim_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .first_fail(ff_a), .fail_seen(fs_a));

    gate_sweep_bist #(.N_IN(3), .SETTLE(3)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .op(op_b),
        .dut_y(dut_y_b), .stim(stim_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .first_fail(ff_b), .fail_seen(fs_b));

    gate_sweep_bist #(.N_IN(2), .SETTLE(2)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .abort(abort_c), .op(op_c),
        .dut_y(dut_y_c), .stim(stim_c), .busy(busy_c), .done(done_c), .pass(pass_c),
        .err_count(err_c), .first_fail(ff_c), .fail_seen(fs_c));

    typedef struct {
        logic [2:0] op;
        int         mode;
        logic [2:0] mfn;
        int         err;
        int         ff;
        bit         fs;
        bit         pass;
    } vec_t;

    vec_t vt[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Runs instance B from a start pulse to DONE, returning busy cycles and stim-order flag.
    task automatic run_b(input logic [2:0] opv, output int nb, output bit seq_ok);
        int n;
        op_b = opv; start_b = 1'b1;
        tick();
        start_b = 1'b0;
        nb = 0; seq_ok = 1'b1; n = 0;
        while (!done_b && n < 200) begin
            if (busy_b) begin
                if (stim_b !== 3'(nb / 4)) seq_ok = 1'b0;
                nb++;
            end
            tick();
            n++;
        end
    endtask

    initial begin
        int nb, n;
        bit seq_ok;

        // op, dut mode, dut function, err_count, first_fail, fail_seen, pass
        vt[0] = '{3'd0, 0, 3'd0, 0, 0, 1'b0, 1'b1}; // AND, correct AND
        vt[1] = '{3'd1, 1, 3'd0, 3, 1, 1'b1, 1'b0}; // OR, stuck-at-0
        vt[2] = '{3'd2, 0, 3'd0, 3, 1, 1'b1, 1'b0}; // XOR, gate is AND
        vt[3] = '{3'd3, 2, 3'd0, 1, 3, 1'b1, 1'b0}; // NAND, stuck-at-1
        vt[4] = '{3'd4, 1, 3'd0, 1, 0, 1'b1, 1'b0}; // NOR, stuck-at-0
        vt[5] = '{3'd5, 0, 3'd2, 4, 0, 1'b1, 1'b0}; // XNOR, gate is XOR: every vector fails
        vt[6] = '{3'd5, 0, 3'd5, 0, 0, 1'b0, 1'b1}; // XNOR, correct XNOR

        rst_n = 1'b0;
        start_a = 0; abort_a = 0; op_a = 0; mode_a = 0; mfn_a = 0;
        start_b = 0; abort_b = 0; op_b = 0; mode_b = 0; mfn_b = 0;
        start_c = 0; abort_c = 0; op_c = 0; mode_c = 0; mfn_c = 0;
        tick();
        tick();
        chk("rst_stim", 32'(stim_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_done", 32'(done_a), 0);
        chk("rst_pass", 32'(pass_a), 0);
        chk("rst_err", 32'(err_a), 0);
        chk("rst_fs", 32'(fs_a), 0);
        rst_n = 1'b1;
        tick();

        // ---------------- Table-driven sweeps on instance A ----------------
        for (int k = 0; k < 7; k++) begin
            mode_a = vt[k].mode; mfn_a = vt[k].mfn; op_a = vt[k].op;
            start_a = 1'b1;
            tick();
            start_a = 1'b0;
            nb = 0; seq_ok = 1'b1; n = 0;
            while (!done_a && n < 100) begin
                if (busy_a) begin
                    if (stim_a !== 2'(nb / 2)) seq_ok = 1'b0;
                    nb++;
                end
                tick();
                n++;
            end
            chk($sformatf("a%0d_done", k), 32'(done_a), 1);
            chk($sformatf("a%0d_busy_cycles", k), 32'(nb), 8);
            chk($sformatf("a%0d_stim_order", k), 32'(seq_ok), 1);
            chk($sformatf("a%0d_busy_low", k), 32'(busy_a), 0);
            chk($sformatf("a%0d_stim_final", k), 32'(stim_a), 3);
            chk($sformatf("a%0d_err", k), 32'(err_a), 32'(vt[k].err));
            chk($sformatf("a%0d_first_fail", k), 32'(ff_a), 32'(vt[k].ff));
            chk($sformatf("a%0d_fail_seen", k), 32'(fs_a), 32'(vt[k].fs));
            chk($sformatf("a%0d_pass", k), 32'(pass_a), 32'(vt[k].pass));
        end

        // DONE holds its results while idle inputs are present.
        tick(); tick(); tick();
        chk("a_hold_done", 32'(done_a), 1);
        chk("a_hold_stim", 32'(stim_a), 3);
        chk("a_hold_pass", 32'(pass_a), 1);

        // ---------------- Instance B: 3-input parity, SETTLE=3 ----------------
        mode_b = 0; mfn_b = 3'd2;
        run_b(3'd2, nb, seq_ok);
        chk("b_xor_done", 32'(done_b), 1);
        chk("b_xor_cycles", 32'(nb), 32);
        chk("b_xor_order", 32'(seq_ok), 1);
        chk("b_xor_pass", 32'(pass_b), 1);
        chk("b_xor_err", 32'(err_b), 0);
        run_b(3'd5, nb, seq_ok);
        chk("b_xnor_done", 32'(done_b), 1);
        chk("b_xnor_cycles", 32'(nb), 32);
        chk("b_xnor_err", 32'(err_b), 8);
        chk("b_xnor_ff", 32'(ff_b), 0);
        chk("b_xnor_fs", 32'(fs_b), 1);
        chk("b_xnor_pass", 32'(pass_b), 0);

        // ---------------- Instance C: stuck-at-1 against AND, SETTLE=2 ----------------
        mode_c = 2;
        op_c = 3'd0; start_c = 1'b1;
        tick();
        start_c = 1'b0;
        tick(); tick(); tick();
        // A start with a new op mid-sweep, then op left changed: neither may take effect.
        start_c = 1'b1; op_c = 3'd1;
        tick();
        start_c = 1'b0; op_c = 3'd4;
        n = 0; nb = 4;
        while (!done_c && n < 100) begin
            if (busy_c) nb++;
            tick();
            n++;
        end
        chk("c_mid_done", 32'(done_c), 1);
        chk("c_mid_cycles", 32'(nb), 12);
        chk("c_mid_err", 32'(err_c), 3);
        chk("c_mid_ff", 32'(ff_c), 0);
        chk("c_mid_pass", 32'(pass_c), 0);

        // abort beats start in the same cycle from DONE.
        abort_c = 1'b1; start_c = 1'b1; op_c = 3'd0;
        tick();
        abort_c = 1'b0; start_c = 1'b0;
        chk("c_abst_busy", 32'(busy_c), 0);
        chk("c_abst_done", 32'(done_c), 0);
        chk("c_abst_stim", 32'(stim_c), 0);
        tick();
        chk("c_abst_idle", 32'(busy_c), 0);

        // Abort when stim reaches 2'b10.
        op_c = 3'd0; start_c = 1'b1;
        tick();
        start_c = 1'b0;
        n = 0;
        while (stim_c != 2'b10 && n < 50) begin
            tick();
            n++;
        end
        chk("c_reach_10", 32'(stim_c), 2);
        abort_c = 1'b1;
        tick();
        abort_c = 1'b0;
        chk("c_ab_stim", 32'(stim_c), 0);
        chk("c_ab_busy", 32'(busy_c), 0);
        chk("c_ab_done", 32'(done_c), 0);
        chk("c_ab_err", 32'(err_c), 2);
        chk("c_ab_ff", 32'(ff_c), 0);
        chk("c_ab_fs", 32'(fs_c), 1);
        tick(); tick();
        chk("c_ab_stays_idle", 32'(busy_c), 0);

        // Reset during WAIT at stim=2'b01.
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        n = 0;
        while (stim_c != 2'b01 && n < 50) begin
            tick();
            n++;
        end
        chk("c_reach_01", 32'(stim_c), 1);
        chk("c_pre_rst_err", 32'(err_c), 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("c_rst_stim", 32'(stim_c), 0);
        chk("c_rst_busy", 32'(busy_c), 0);
        chk("c_rst_done", 32'(done_c), 0);
        chk("c_rst_pass", 32'(pass_c), 0);
        chk("c_rst_err", 32'(err_c), 0);
        chk("c_rst_ff", 32'(ff_c), 0);
        chk("c_rst_fs", 32'(fs_c), 0);

        // Reserved op is refused.
        op_c = 3'd7; start_c = 1'b1;
        tick();
        start_c = 1'b0;
        chk("c_op7_busy", 32'(busy_c), 0);
        tick(); tick();
        chk("c_op7_busy_later", 32'(busy_c), 0);
        chk("c_op7_stim", 32'(stim_c), 0);
        chk("c_op7_done", 32'(done_c), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gate_sweep_bist.md
Name: gate_sweep_bist

Overview:
- Hardware successor to the exhaustive truth-table bench used for the 2-input gate cells.
- Drives every one of the 2^N_IN input combinations onto an N-input combinational gate under test and waits a programmable settle time per vector.
- Samples the gate's output and compares it against an internal reference model selected by op, counting mismatches and recording the first failing vector.
- Sits beside any gate cell in the digital-design exercises as a synthesizable self-checker with a start/done handshake.

Parameters:
- N_IN, 2, number of gate inputs (1..8); stim width; 2^N_IN vectors per sweep.
- SETTLE, 1, cycles stim is held before dut_y is sampled (>=1).

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  begin sweep; sampled only in IDLE or DONE.
- abort  input  1  terminate sweep, return to IDLE.
- op  input  3  reference function: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6-7 reserved.
- dut_y  input  1  output of the gate under test.
- stim  output  N_IN  input vector driven to the gate under test.
- busy  output  1  high while sweeping.
- done  output  1  high in DONE; results valid.
- pass  output  1  valid when done=1; 1 iff err_count==0.
- err_count  output  N_IN+1  number of mismatching vectors; max 2^N_IN, never wraps.
- first_fail  output  N_IN  stim value of the first mismatch.
- fail_seen  output  1  first_fail is valid.

Behaviour:
- Reset (rst_n=0 at an edge) has priority over all other inputs, including mid-sweep. It forces:
  - state=IDLE
  - stim=0, busy=0, done=0, pass=0
  - err_count=0, first_fail=0, fail_seen=0
  - internal settle counter=0
- FSM states are IDLE, WAIT, CHECK and DONE.
- IDLE or DONE with start=1 and op<=5:
  - latch op into op_q; clear stim, err_count, first_fail, fail_seen, settle counter.
  - set busy=1, done=0, pass=0; go to WAIT.
- start with op>=6 is ignored; the state is unchanged.
- WAIT:
  - increment settle counter.
  - when the counter reaches SETTLE-1, clear it and go to CHECK.
  - WAIT therefore lasts SETTLE cycles.
- CHECK:
  - exp = reduction of stim per op_q (AND/OR/XOR; NAND/NOR/XNOR are inverted).
  - if dut_y != exp: err_count+1; if fail_seen=0, set first_fail=stim and fail_seen=1.
  - if stim == all ones: go to DONE with busy=0, done=1, pass=(final err_count==0), including the current check.
  - otherwise: stim+1, go to WAIT.
- Sweep length: 2^N_IN*(SETTLE+1) cycles from the first WAIT cycle to the first DONE cycle.
- DONE holds all results and stim=all ones until start, abort or reset.
- start while in WAIT or CHECK is ignored; op changes during a sweep are ignored because op_q is used.
- abort=1 in any non-IDLE state goes to IDLE:
  - busy=0, done=0, pass=0, stim=0.
  - err_count, first_fail and fail_seen keep their values for debug.
- abort has priority over start in the same cycle.
- dut_y is sampled only in CHECK; its value in other states has no effect.

Test Plan:
- N_IN=2, SETTLE=1, op=0, DUT = correct AND; pulse start -> stim runs 00,01,10,11; busy high for 8 cycles; done=1, pass=1, err_count=0, fail_seen=0.
- N_IN=2, op=1 (OR), DUT stuck-at-0 -> err_count=3, first_fail=2'b01, fail_seen=1, pass=0.
- N_IN=3, SETTLE=3, op=2 (XOR), DUT = correct 3-input parity -> done after 32 cycles, pass=1. Then repeat with op=5 on the same DUT -> err_count=8, first_fail=3'b000.
- Start run (N_IN=2, SETTLE=2, op=0, stuck-at-1 DUT):
  - assert start and change op mid-sweep -> both ignored; final err_count=3.
  - assert abort at stim=2'b10 -> IDLE, stim=0, busy=0, err_count=2, first_fail=2'b00.
- Deassert rst_n for one cycle during WAIT at stim=2'b01 -> all outputs return to reset values next cycle. start with op=7 -> stays IDLE, busy=0.
